// File: rtl/mc_control_pkg.sv
// mc_control_pkg: encodings shared by the multi-cycle sequencer, the
// datapath muxes it steers, and the bench.
//   - opcode values (IR[31:26])
//   - sequencer state enum
//   - alu_op, alu_src_b and pc_source select encodings
package mc_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SHIFT = 6'b110000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_EXEC_SH,
    S_R_WB,
    S_EXEC_I,
    S_I_WB,
    S_BRANCH,
    S_JUMP
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: per-instruction sequencer for the multi-cycle MIPS-32
// datapath. One memory port and one ALU are time-shared across
// fetch/decode/execute/memory/write-back.
// Ports:
//   clk, reset (sync, active-high)
//   opcode     IR[31:26], sampled in DECODE
//   mem_ready  memory completes current access this cycle
//   pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
//   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
//   pc_source  datapath controls
//   instr_done pulse in final cycle of each instruction
//   illegal_op pulse in DECODE on an unrecognised opcode
//   retired    count of instr_done pulses (wraps)
module multicycle_control
  import mc_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  state_t     state, next;
  logic [5:0] op_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      op_q    <= '0;
      retired <= '0;
    end else begin
      state <= next;
      if (state == S_DECODE) op_q <= opcode;
      if (instr_done)        retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    next          = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    // Outputs are forced quiet during reset so an aborted instruction
    // cannot leak a write enable into the reset cycle.
    if (reset) begin
      next = S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            next     = S_DECODE;
          end
        end
        S_DECODE: begin
          // ALU idle here, so it precomputes the branch target into ALUOut.
          // op_q is not loaded yet, so decode uses the live opcode.
          alu_src_b = SRCB_IMM_SH;
          case (opcode)
            OP_LW, OP_SW: next = S_MEM_ADDR;
            OP_RTYPE:     next = S_EXEC_R;
            OP_SHIFT:     next = S_EXEC_SH;
            OP_ADDI,
            OP_ANDI:      next = S_EXEC_I;
            OP_BEQ:       next = S_BRANCH;
            OP_J:         next = S_JUMP;
            default: begin
              illegal_op = 1'b1;
              next       = S_FETCH;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          next      = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) next = S_MEM_WB;
        end
        S_MEM_WB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next       = S_FETCH;
        end
        S_MEM_WR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            next       = S_FETCH;
          end
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_B;
          alu_op    = ALU_FUNCT;
          next      = S_R_WB;
        end
        S_EXEC_SH: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_FUNCT;
          next      = S_R_WB;
        end
        S_R_WB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next       = S_FETCH;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = (op_q == OP_ANDI) ? ALU_AND : ALU_ADD;
          next      = S_I_WB;
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next       = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRCB_B;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          instr_done    = 1'b1;
          next          = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          instr_done = 1'b1;
          next       = S_FETCH;
        end
        default: next = S_FETCH;
      endcase
    end
  end

endmodule
